// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between an instruction-fetch
// port and a data-access port; D wins ties unless it was granted last.
module unified_mem_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 m_read,
    output logic                 m_write,
    output logic [WORD_SIZE-1:0] m_addr,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    output logic                 busy
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               last_grant_r;   // 1'b1 = D was granted last
    logic               grant_d_r;      // port owning the current access
    logic               d_pend_s;
    logic               take_d_s;

    assign d_pend_s = d_read | d_write;
    assign take_d_s = d_pend_s & (~i_req | ~last_grant_r);

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            last_grant_r <= 1'b0;
            grant_d_r    <= 1'b0;
            i_rdata      <= {WORD_SIZE{1'b0}};
            d_rdata      <= {WORD_SIZE{1'b0}};
            i_ready      <= 1'b0;
            d_ready      <= 1'b0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_addr       <= {WORD_SIZE{1'b0}};
            m_wdata      <= {WORD_SIZE{1'b0}};
            busy         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    if (take_d_s) begin
                        m_addr       <= d_addr;
                        last_grant_r <= 1'b1;
                        grant_d_r    <= 1'b1;
                        cnt_r        <= CNT_W'(MEM_LATENCY - 1);
                        busy         <= 1'b1;
                        state_r      <= ST_BUSY;
                        // a simultaneous read+write is carried out as a write only
                        if (d_write) begin
                            m_write <= 1'b1;
                            m_wdata <= d_wdata;
                        end else begin
                            m_read  <= 1'b1;
                        end
                    end else if (i_req) begin
                        m_addr       <= i_addr;
                        m_read       <= 1'b1;
                        last_grant_r <= 1'b0;
                        grant_d_r    <= 1'b0;
                        cnt_r        <= CNT_W'(MEM_LATENCY - 1);
                        busy         <= 1'b1;
                        state_r      <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        if (m_read && grant_d_r) begin
                            d_rdata <= m_rdata;
                        end else if (m_read) begin
                            i_rdata <= m_rdata;
                        end else begin
                            d_rdata <= d_rdata;
                        end
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        d_ready <= grant_d_r;
                        i_ready <= ~grant_d_r;
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    m_read  <= 1'b0;
                    m_write <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized self-checking bench for unified_mem_arbiter against a transaction-level
// model of grant order, strobe window, ready pulse and held data.
module tb_unified_mem_arbiter;

    localparam int W   = 16;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_req;
    logic [W-1:0] i_addr;
    logic [W-1:0] i_rdata;
    logic         i_ready;
    logic         d_read;
    logic         d_write;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic [W-1:0] d_rdata;
    logic         d_ready;
    logic         m_read;
    logic         m_write;
    logic [W-1:0] m_addr;
    logic [W-1:0] m_wdata;
    logic [W-1:0] m_rdata;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // model state
    bit           last_was_d;
    logic [W-1:0] exp_i_rdata;
    logic [W-1:0] exp_d_rdata;
    logic [W-1:0] exp_addr;
    logic [W-1:0] exp_wdata;
    string        grant_log;

    unified_mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_was_d  = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        exp_addr    = '0;
        exp_wdata   = '0;
    endtask

    task automatic drive_idle();
        i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_val({tag, "_i_rdata"}, i_rdata, 16'h0000);
        chk_val({tag, "_d_rdata"}, d_rdata, 16'h0000);
        chk_val({tag, "_rdy"}, {14'd0, i_ready, d_ready}, 16'h0000);
        chk_val({tag, "_strb"}, {14'd0, m_read, m_write}, 16'h0000);
        chk_val({tag, "_m_addr"}, m_addr, 16'h0000);
        chk_val({tag, "_m_wdata"}, m_wdata, 16'h0000);
        chk_val({tag, "_busy"}, {15'd0, busy}, 16'h0000);
    endtask

    task automatic chk_quiet(input string tag);
        chk_val({tag, "_busy"}, {15'd0, busy}, 16'h0000);
        chk_val({tag, "_rdy"}, {14'd0, i_ready, d_ready}, 16'h0000);
        chk_val({tag, "_strb"}, {14'd0, m_read, m_write}, 16'h0000);
        chk_val({tag, "_hold_i"}, i_rdata, exp_i_rdata);
        chk_val({tag, "_hold_d"}, d_rdata, exp_d_rdata);
        chk_val({tag, "_m_addr"}, m_addr, exp_addr);
        chk_val({tag, "_m_wdata"}, m_wdata, exp_wdata);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_access(input bit ir, input bit dr, input bit dw,
                             input logic [W-1:0] ia, input logic [W-1:0] da,
                             input logic [W-1:0] dwd, input bit glitch,
                             input logic [W-1:0] rd_fixed, input bit use_fixed);
        bit           dp, gd, wr;
        logic [W-1:0] data;
        i_req = ir; d_read = dr; d_write = dw;
        i_addr = ia; d_addr = da; d_wdata = dwd;
        dp = dr | dw;
        if (!ir && !dp) begin
            @(posedge clk);
            @(negedge clk);
            chk_quiet("no_req");
            return;
        end
        if (ir && dp) gd = !last_was_d;
        else          gd = dp;
        wr = gd && dw;
        last_was_d = gd;
        grant_log = {grant_log, gd ? "D" : "I"};
        exp_addr = gd ? da : ia;
        if (wr) exp_wdata = dwd;
        data = '0;
        @(posedge clk);
        for (int o = 1; o <= LAT; o++) begin
            @(negedge clk);
            m_rdata = use_fixed ? rd_fixed : W'($urandom);
            if (o == LAT) data = m_rdata;
            chk_val("strobe_rd", {15'd0, m_read}, {15'd0, !wr});
            chk_val("strobe_wr", {15'd0, m_write}, {15'd0, wr});
            chk_val("strobe_addr", m_addr, exp_addr);
            chk_val("strobe_wdata", m_wdata, exp_wdata);
            chk_val("strobe_busy", {15'd0, busy}, 16'h0001);
            chk_val("strobe_rdy", {14'd0, i_ready, d_ready}, 16'h0000);
            if (glitch && o == 1) begin
                i_req = 1'($urandom); d_read = 1'($urandom); d_write = 1'($urandom);
                i_addr = W'($urandom); d_addr = W'($urandom); d_wdata = W'($urandom);
            end
        end
        @(negedge clk);
        m_rdata = W'($urandom);
        if (!wr) begin
            if (gd) exp_d_rdata = data;
            else    exp_i_rdata = data;
        end
        chk_val("resp_i_ready", {15'd0, i_ready}, {15'd0, !gd});
        chk_val("resp_d_ready", {15'd0, d_ready}, {15'd0, gd});
        chk_val("resp_i_rdata", i_rdata, exp_i_rdata);
        chk_val("resp_d_rdata", d_rdata, exp_d_rdata);
        chk_val("resp_strb", {14'd0, m_read, m_write}, 16'h0000);
        chk_val("resp_busy", {15'd0, busy}, 16'h0001);
        chk_val("resp_m_addr", m_addr, exp_addr);
        drive_idle();
        @(negedge clk);
        chk_quiet("post_idle");
    endtask

    initial begin
        reset_n = 1'b0;
        drive_idle();
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        grant_log = "";
        model_reset();
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_quiet("idle0");

        // T2: instruction read
        do_access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 16'hABCD, 1'b1);
        chk_val("t2_i_rdata", exp_i_rdata, 16'hABCD);
        // T3: data write
        do_access(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'h1234, 1'b0, 16'h5555, 1'b1);
        // data read to give d_rdata a known prior value
        do_access(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0030, 16'h0000, 1'b0, 16'h4321, 1'b1);
        // T6: read+write together acts as a write
        do_access(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0040, 16'h00FF, 1'b0, 16'h7777, 1'b1);
        chk_val("t6_d_rdata_kept", d_rdata, 16'h4321);

        // T4: both pending from reset -> D,I,D,I
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_all_zero("t4_reset");
        @(negedge clk);
        reset_n = 1'b1;
        grant_log = "";
        for (int n = 0; n < 4; n++)
            do_access(1'b1, 1'b1, 1'b0, 16'h0100 + W'(n), 16'h0200 + W'(n), 16'h0000,
                      1'b0, 16'h0000, 1'b0);
        checks++;
        if (grant_log != "DIDI") begin
            errors++;
            $display("FAIL t4_order: got %s expected DIDI", grant_log);
        end

        // T1/T5: reset in the first BUSY cycle of an I read
        i_req = 1'b1; i_addr = 16'h0055;
        @(posedge clk);
        @(negedge clk);
        chk_val("t5_strobe", {15'd0, m_read}, 16'h0001);
        reset_n = 1'b0;
        drive_idle();
        #1;
        model_reset();
        chk_all_zero("t1_async");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk_quiet("t5_after");
        end

        // randomized traffic with request churn while busy
        for (int n = 0; n < 80; n++) begin
            do_access(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      W'($urandom), W'($urandom), W'($urandom), 1'($urandom), 16'h0000, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
